// File: rtl/pc_next_unit_if.sv
// Interface bundling the program-counter datapath signals.
// The control/immediate side is the master; pc_next_unit is the slave.
interface pc_next_unit_if #(
  parameter int unsigned XLEN = 32
);

  // Next-PC select from the control unit: 0 = PCplus4, 1 = PCtarget
  logic            PCsrc;
  // Sign-extended branch/jump offset in bytes
  logic [XLEN-1:0] ImmExt;
  // Registered current PC (drives the instruction memory address)
  logic [XLEN-1:0] PC;
  // Combinational sequential address
  logic [XLEN-1:0] PCplus4;
  // Combinational branch/jump target
  logic [XLEN-1:0] PCtarget;
  // Combinational selected next PC
  logic [XLEN-1:0] PCNext;

  // Control side: drives the select and offset, observes the addresses
  modport master (
    output PCsrc,
    output ImmExt,
    input  PC,
    input  PCplus4,
    input  PCtarget,
    input  PCNext
  );

  // PC unit side: consumes the select and offset, produces the addresses
  modport slave (
    input  PCsrc,
    input  ImmExt,
    output PC,
    output PCplus4,
    output PCtarget,
    output PCNext
  );

endinterface : pc_next_unit_if

// File: rtl/pc_next_unit.sv
// Program-counter datapath for the single-cycle RV32 core.
// Holds the PC register, forms PC+4 and PC+ImmExt, and selects the next PC.
// All adds are unsigned modulo 2^XLEN; no alignment checks or masking.
module pc_next_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic             clk,
  input logic             reset,
  pc_next_unit_if.slave   bus
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_pc_target;
  logic [XLEN-1:0] w_pc_next;

  // Address arithmetic: plain wrap-around adds. A negative ImmExt is a
  // two's-complement value, so a backward branch needs no subtractor.
  always_comb begin
    w_pc_plus4  = r_pc + PC_STEP;
    w_pc_target = r_pc + bus.ImmExt;
  end

  // Next-PC select: a plain 2:1 mux, zero latency from PCsrc/ImmExt.
  always_comb begin
    w_pc_next = w_pc_plus4;
    if (bus.PCsrc) begin
      w_pc_next = w_pc_target;
    end
  end

  // PC register: synchronous reset wins over the selected next PC; the PC
  // advances every non-reset cycle because there is no stall input.
  // NOTE: non-blocking assignment so every sequential reader sees the
  // pre-edge PC value regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign bus.PC       = r_pc;
  assign bus.PCplus4  = w_pc_plus4;
  assign bus.PCtarget = w_pc_target;
  assign bus.PCNext   = w_pc_next;

endmodule : pc_next_unit

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: reset, sequential and branch stepping,
// wrap-around, mid-run reset, reset glitch between edges, and the
// combinational paths between edges.
module tb_pc_next_unit;

  localparam int unsigned XLEN = 32;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  pc_next_unit_if #(.XLEN(XLEN)) bus ();

  pc_next_unit #(
    .XLEN     (XLEN),
    .RESET_PC ('0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] actual,
                       input logic [XLEN-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, actual, expected);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b1;
    bus.PCsrc  = 1'b0;
    bus.ImmExt = 32'd16;

    // Reset edge
    tick();
    check("rst_pc",     bus.PC,       32'h0000_0000);
    check("rst_plus4",  bus.PCplus4,  32'h0000_0004);
    check("rst_target", bus.PCtarget, 32'h0000_0010);
    check("rst_next",   bus.PCNext,   32'h0000_0004);

    // Sequential step
    reset = 1'b0;
    tick();
    check("seq_pc",    bus.PC,      32'h0000_0004);
    check("seq_plus4", bus.PCplus4, 32'h0000_0008);

    // Forward branch from PC=4, same-cycle target then registered
    bus.PCsrc  = 1'b1;
    bus.ImmExt = 32'd8;
    #1;
    check("br_target", bus.PCtarget, 32'h0000_000C);
    check("br_next",   bus.PCNext,   32'h0000_000C);
    tick();
    check("br_pc", bus.PC, 32'h0000_000C);

    bus.PCsrc = 1'b0;
    tick();
    check("seq2_pc", bus.PC, 32'h0000_0010);

    bus.PCsrc  = 1'b1;
    bus.ImmExt = 32'd20;
    #1;
    check("br2_next", bus.PCNext, 32'h0000_0024);
    tick();
    check("br2_pc", bus.PC, 32'h0000_0024);

    // Backward branches: 0x24 - 4 -> 0x20, then 0x20 - 8 -> 0x18
    bus.ImmExt = 32'hFFFF_FFFC;
    tick();
    check("back1_pc", bus.PC, 32'h0000_0020);
    bus.ImmExt = 32'hFFFF_FFF8;
    #1;
    check("back2_target", bus.PCtarget, 32'h0000_0018);
    tick();
    check("back2_pc", bus.PC, 32'h0000_0018);

    // Jump to top of address space, then PC+4 wraps to zero
    bus.ImmExt = 32'hFFFF_FFE4;
    tick();
    check("top_pc",    bus.PC,      32'hFFFF_FFFC);
    check("wrap_plus4", bus.PCplus4, 32'h0000_0000);
    bus.PCsrc = 1'b0;
    tick();
    check("wrap_pc", bus.PC, 32'h0000_0000);

    // Target wrap: PC=FFFFFFF0, ImmExt=0x20 -> 0x10
    bus.PCsrc  = 1'b1;
    bus.ImmExt = 32'hFFFF_FFF0;
    tick();
    check("fff0_pc", bus.PC, 32'hFFFF_FFF0);
    bus.ImmExt = 32'h0000_0020;
    #1;
    check("wrap_target", bus.PCtarget, 32'h0000_0010);
    tick();
    check("wrap_tgt_pc", bus.PC, 32'h0000_0010);

    // Mid-run reset overrides a pending branch
    bus.ImmExt = 32'h0000_0014;
    tick();
    check("pre_rst_pc", bus.PC, 32'h0000_0024);
    reset      = 1'b1;
    bus.ImmExt = 32'h0000_0100;
    #1;
    check("rst_comb_next", bus.PCNext, 32'h0000_0124);
    tick();
    check("midrst_pc",     bus.PC,       32'h0000_0000);
    check("midrst_plus4",  bus.PCplus4,  32'h0000_0004);
    check("midrst_target", bus.PCtarget, 32'h0000_0100);
    check("midrst_next",   bus.PCNext,   32'h0000_0100);

    // Reset pulsed strictly between edges has no effect
    reset     = 1'b0;
    bus.PCsrc = 1'b0;
    tick();
    check("post_rst_pc", bus.PC, 32'h0000_0004);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("glitch_pc", bus.PC, 32'h0000_0004);

    // Combinational paths follow PCsrc/ImmExt between edges; PC holds
    bus.PCsrc  = 1'b1;
    bus.ImmExt = 32'd3;
    #1;
    check("comb_target", bus.PCtarget, 32'h0000_0007);
    check("comb_next1",  bus.PCNext,   32'h0000_0007);
    check("comb_pc1",    bus.PC,       32'h0000_0004);
    bus.PCsrc = 1'b0;
    #1;
    check("comb_next0", bus.PCNext, 32'h0000_0008);
    bus.PCsrc  = 1'b1;
    bus.ImmExt = 32'hFFFF_FFFF;
    #1;
    check("comb_next_neg", bus.PCNext, 32'h0000_0003);
    check("comb_pc2",      bus.PC,     32'h0000_0004);

    // Misaligned target is passed straight through
    tick();
    check("misalign_pc",    bus.PC,      32'h0000_0003);
    check("misalign_plus4", bus.PCplus4, 32'h0000_0007);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pc_next_unit
